// File: rtl/alu_pkg.sv
// alu_pkg: shared op codes, flag indices and width default.
// Imported by alu_core and alu_conv.
package alu_pkg;

   localparam int ALU_WIDTH = 8;

   localparam logic [2:0] OP_ADD = 3'b000;
   localparam logic [2:0] OP_SUB = 3'b001;
   localparam logic [2:0] OP_OR  = 3'b010;
   localparam logic [2:0] OP_AND = 3'b011;
   localparam logic [2:0] OP_XOR = 3'b100;
   localparam logic [2:0] OP_NOT = 3'b101;
   localparam logic [2:0] OP_LSL = 3'b110;
   localparam logic [2:0] OP_LSR = 3'b111;

   localparam int FLAG_N = 3;
   localparam int FLAG_Z = 2;
   localparam int FLAG_C = 1;
   localparam int FLAG_V = 0;

endpackage

// File: rtl/alu_core.sv
// alu_core: combinational A/B/ctrl -> result.
// Flags port and logic exist only with ALU_FLAGS_EN.
module alu_core
   import alu_pkg::*;
#(
   parameter int WIDTH = ALU_WIDTH
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [2:0]       ctrl,
`ifdef ALU_FLAGS_EN
   output logic [3:0]       flags,
`endif
   output logic [WIDTH-1:0] result
);

   logic [WIDTH-1:0] r_add;
   logic [WIDTH-1:0] r_sub;
   logic [WIDTH-1:0] r_shl;
   logic [WIDTH-1:0] r_shr;

`ifdef ALU_FLAGS_EN
   logic [WIDTH:0] sum;
   logic [WIDTH:0] dif;
   logic [WIDTH:0] shl;
   logic [WIDTH:0] shr;

   // Extra bit on each path catches carry/borrow/last bit out.
   assign sum   = {1'b0, a} + {1'b0, b};
   assign dif   = {1'b0, a} - {1'b0, b};
   assign shl   = {1'b0, a} << b;
   assign shr   = {a, 1'b0} >> b;
   assign r_add = sum[WIDTH-1:0];
   assign r_sub = dif[WIDTH-1:0];
   assign r_shl = shl[WIDTH-1:0];
   assign r_shr = shr[WIDTH:1];

   // Flag derivation from the selected result and op.
   always_comb begin
      flags         = '0;
      flags[FLAG_N] = result[WIDTH-1];
      flags[FLAG_Z] = (result == '0);
      unique case (ctrl)
         OP_ADD: begin
            flags[FLAG_C] = sum[WIDTH];
            flags[FLAG_V] = (a[WIDTH-1] == b[WIDTH-1]) &&
                            (r_add[WIDTH-1] != a[WIDTH-1]);
         end
         OP_SUB: begin
            flags[FLAG_C] = dif[WIDTH];
            flags[FLAG_V] = (a[WIDTH-1] != b[WIDTH-1]) &&
                            (r_sub[WIDTH-1] != a[WIDTH-1]);
         end
         OP_LSL:  flags[FLAG_C] = shl[WIDTH];
         OP_LSR:  flags[FLAG_C] = shr[0];
         default: flags[FLAG_C] = 1'b0;
      endcase
   end
`else
   // Shift amounts >= WIDTH naturally produce zero.
   assign r_add = a + b;
   assign r_sub = a - b;
   assign r_shl = a << b;
   assign r_shr = a >> b;
`endif

   // Result select by op code.
   always_comb begin
      result = '0;
      unique case (ctrl)
         OP_ADD:  result = r_add;
         OP_SUB:  result = r_sub;
         OP_OR:   result = a | b;
         OP_AND:  result = a & b;
         OP_XOR:  result = a ^ b;
         OP_NOT:  result = ~a;
         OP_LSL:  result = r_shl;
         OP_LSR:  result = r_shr;
         default: result = '0;
      endcase
   end

endmodule

// File: rtl/alu_conv.sv
// alu_conv: operand A mux, registered ALU result and valid.
// Optional flags register enabled by ALU_FLAGS_EN.
module alu_conv
   import alu_pkg::*;
#(
   parameter int WIDTH = ALU_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] a0_mux,
   input  logic [WIDTH-1:0] a1_mux,
   input  logic             a_sel,
   input  logic [WIDTH-1:0] b,
   input  logic [2:0]       ctrl,
   output logic [WIDTH-1:0] out,
   output logic             out_valid,
   output logic [3:0]       flags
);

   logic [WIDTH-1:0] op_a;
   logic [WIDTH-1:0] res;

   assign op_a = a_sel ? a1_mux : a0_mux;

`ifdef ALU_FLAGS_EN
   logic [3:0] res_flags;

   alu_core #(.WIDTH(WIDTH)) u_core (
      .a      (op_a),
      .b      (b),
      .ctrl   (ctrl),
      .flags  (res_flags),
      .result (res)
   );

   // Flags follow the same capture rule as the result.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         flags <= '0;
      end else if (in_valid) begin
         flags <= res_flags;
      end
   end
`else
   alu_core #(.WIDTH(WIDTH)) u_core (
      .a      (op_a),
      .b      (b),
      .ctrl   (ctrl),
      .result (res)
   );

   assign flags = 4'b0000;
`endif

   // Capture result on valid issue; valid marks a fresh result.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out       <= '0;
         out_valid <= 1'b0;
      end else begin
         out_valid <= in_valid;
         if (in_valid) begin
            out <= res;
         end
      end
   end

endmodule

// File: tb/tb_alu_conv.sv
// tb_alu_conv: randomized and directed checks of alu_conv
// against an arithmetic reference model.
module tb_alu_conv;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       in_valid = 1'b0;
   logic [7:0] a0_mux = '0;
   logic [7:0] a1_mux = '0;
   logic       a_sel = 1'b0;
   logic [7:0] b = '0;
   logic [2:0] ctrl = '0;
   logic [7:0] out;
   logic       out_valid;
   logic [3:0] flags;

   int checks = 0;
   int failures = 0;

   alu_conv dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .a0_mux    (a0_mux),
      .a1_mux    (a1_mux),
      .a_sel     (a_sel),
      .b         (b),
      .ctrl      (ctrl),
      .out       (out),
      .out_valid (out_valid),
      .flags     (flags)
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] ref_res(int a, int bb, int op);
      int r;
      case (op)
         0: r = a + bb;
         1: r = a - bb + 256;
         2: r = a | bb;
         3: r = a & bb;
         4: r = a ^ bb;
         5: r = 255 - a;
         6: r = (bb >= 8) ? 0 : a * (1 << bb);
         default: r = (bb >= 8) ? 0 : a / (1 << bb);
      endcase
      return 8'(r % 256);
   endfunction

   function automatic logic [3:0] ref_flags(int a, int bb, int op);
      int r, sa, sb, ss;
      logic n, z, c, v;
      r  = int'(ref_res(a, bb, op));
      sa = (a >= 128) ? a - 256 : a;
      sb = (bb >= 128) ? bb - 256 : bb;
      n  = (r >= 128);
      z  = (r == 0);
      c  = 1'b0;
      v  = 1'b0;
      case (op)
         0: begin
            c  = (a + bb) > 255;
            ss = sa + sb;
            v  = (ss > 127) || (ss < -128);
         end
         1: begin
            c  = a < bb;
            ss = sa - sb;
            v  = (ss > 127) || (ss < -128);
         end
         6: if (bb >= 1 && bb <= 8) c = ((a >> (8 - bb)) & 1) != 0;
         7: if (bb >= 1 && bb <= 8) c = ((a >> (bb - 1)) & 1) != 0;
         default: c = 1'b0;
      endcase
      return {n, z, c, v};
   endfunction

   function automatic logic [3:0] exp_flags(int a, int bb, int op);
`ifdef ALU_FLAGS_EN
      return ref_flags(a, bb, op);
`else
      return (a + bb + op) < 0 ? 4'hF : 4'h0;
`endif
   endfunction

   task automatic drive(input logic v, input logic s,
                        input logic [7:0] x0, input logic [7:0] x1,
                        input logic [7:0] y, input logic [2:0] op);
      in_valid = v;
      a_sel    = s;
      a0_mux   = x0;
      a1_mux   = x1;
      b        = y;
      ctrl     = op;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      drive(1'b1, 1'b1, 8'h12, 8'h34, 8'h05, 3'd0);
      repeat (3) @(negedge clk);
      checks++;
      if (out !== 8'h00 || out_valid !== 1'b0 || flags !== 4'h0) begin
         failures++;
         $display("FAIL reset_hold out=%h v=%b f=%h want 00 0 0",
                  out, out_valid, flags);
      end
      rst_n = 1'b1;
      checks++;
      if (out !== 8'h00 || out_valid !== 1'b0) begin
         failures++;
         $display("FAIL reset_release out=%h v=%b want 00 0",
                  out, out_valid);
      end
      @(negedge clk);
      checks++;
      if (out !== 8'h39 || out_valid !== 1'b1) begin
         failures++;
         $display("FAIL reset_first out=%h v=%b want 39 1",
                  out, out_valid);
      end
   endtask

   task automatic test_directed();
      logic [7:0] va [14] = '{8'h10, 8'h07, 8'h41, 8'h4A, 8'h00,
                              8'h01, 8'h03, 8'h22, 8'h47, 8'h02,
                              8'h31, 8'h06, 8'hFF, 8'h80};
      logic [7:0] vb [14] = '{8'h10, 8'h07, 8'h03, 8'h10, 8'h01,
                              8'h12, 8'h10, 8'h12, 8'h55, 8'h01,
                              8'h10, 8'h02, 8'h22, 8'h08};
      logic [2:0] vo [14] = '{3'd0, 3'd0, 3'd1, 3'd1, 3'd1,
                              3'd2, 3'd3, 3'd4, 3'd5, 3'd6,
                              3'd6, 3'd7, 3'd7, 3'd6};
      logic [7:0] ve [14] = '{8'h20, 8'h0E, 8'h3E, 8'h3A, 8'hFF,
                              8'h13, 8'h00, 8'h30, 8'hB8, 8'h04,
                              8'h00, 8'h01, 8'h00, 8'h00};
      logic [3:0] ef;
      for (int i = 0; i < 14; i++) begin
         @(negedge clk);
         drive(1'b1, 1'b1, 8'($urandom), va[i], vb[i], vo[i]);
         @(negedge clk);
         ef = exp_flags(int'(va[i]), int'(vb[i]), int'(vo[i]));
         checks++;
         if (out !== ve[i] || out_valid !== 1'b1 || flags !== ef) begin
            failures++;
            $display("FAIL directed_%0d out=%h v=%b f=%h want %h 1 %h",
                     i, out, out_valid, flags, ve[i], ef);
         end
      end
   endtask

   task automatic test_mux();
      logic [7:0] want [2] = '{8'h18, 8'h20};
      for (int s = 0; s < 2; s++) begin
         @(negedge clk);
         drive(1'b1, s[0], 8'h08, 8'h10, 8'h10, 3'd0);
         @(negedge clk);
         checks++;
         if (out !== want[s]) begin
            failures++;
            $display("FAIL mux_sel%0d out=%h want %h", s, out, want[s]);
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [7:0] exp_q [$];
      logic [7:0] x0, x1, y;
      logic [2:0] op;
      logic       s;
      @(negedge clk);
      for (int k = 0; k <= 40; k++) begin
         if (k > 0) begin
            checks++;
            if (out !== exp_q[0] || out_valid !== 1'b1) begin
               failures++;
               $display("FAIL b2b_%0d out=%h v=%b want %h 1",
                        k, out, out_valid, exp_q[0]);
            end
            void'(exp_q.pop_front());
         end
         x0 = 8'($urandom);
         x1 = 8'($urandom);
         y  = 8'($urandom_range(0, 12));
         op = 3'($urandom);
         s  = 1'($urandom);
         drive(1'b1, s, x0, x1, y, op);
         exp_q.push_back(ref_res(int'(s ? x1 : x0), int'(y), int'(op)));
         @(negedge clk);
      end
      in_valid = 1'b0;
   endtask

   task automatic test_hold();
      @(negedge clk);
      drive(1'b1, 1'b0, 8'h5A, 8'h00, 8'h0F, 3'd3);
      @(negedge clk);
      drive(1'b0, 1'b1, 8'hFF, 8'hFF, 8'h01, 3'd0);
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         checks++;
         if (out !== 8'h0A || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL hold_%0d out=%h v=%b want 0a 0",
                     i, out, out_valid);
         end
      end
   endtask

   task automatic test_random();
      logic [7:0] exp_out;
      logic [3:0] exp_f;
      logic       exp_v;
      logic [7:0] x0, x1, y;
      logic [2:0] op;
      logic       s, v;
      exp_out = out;
      exp_f   = flags;
      exp_v   = out_valid;
      for (int k = 0; k < 300; k++) begin
         checks++;
         if (out !== exp_out || out_valid !== exp_v || flags !== exp_f) begin
            failures++;
            $display("FAIL rand_%0d out=%h v=%b f=%h want %h %b %h",
                     k, out, out_valid, flags, exp_out, exp_v, exp_f);
         end
         x0 = 8'($urandom);
         x1 = 8'($urandom);
         y  = ($urandom_range(0, 3) == 0) ? 8'($urandom)
                                          : 8'($urandom_range(0, 9));
         op = 3'($urandom);
         s  = 1'($urandom);
         v  = ($urandom_range(0, 3) != 0);
         drive(v, s, x0, x1, y, op);
         exp_v = v;
         if (v) begin
            exp_out = ref_res(int'(s ? x1 : x0), int'(y), int'(op));
            exp_f   = exp_flags(int'(s ? x1 : x0), int'(y), int'(op));
         end
         #2 drive(v, ~s, ~x0, ~x1, ~y, ~op);
         #1 drive(v, s, x0, x1, y, op);
         @(negedge clk);
      end
      in_valid = 1'b0;
   endtask

   task automatic test_async_reset();
      @(negedge clk);
      drive(1'b1, 1'b1, 8'h00, 8'h10, 8'h10, 3'd0);
      @(negedge clk);
      checks++;
      if (out !== 8'h20 || out_valid !== 1'b1) begin
         failures++;
         $display("FAIL async_pre out=%h v=%b want 20 1", out, out_valid);
      end
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if (out !== 8'h00 || out_valid !== 1'b0 || flags !== 4'h0) begin
         failures++;
         $display("FAIL async_rst out=%h v=%b f=%h want 00 0 0",
                  out, out_valid, flags);
      end
      @(negedge clk);
      rst_n = 1'b1;
      in_valid = 1'b0;
      @(negedge clk);
      checks++;
      if (out !== 8'h00 || out_valid !== 1'b0) begin
         failures++;
         $display("FAIL async_post out=%h v=%b want 00 0", out, out_valid);
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_mux();
      test_back_to_back();
      test_hold();
      test_random();
      test_async_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/alu_conv.md
Name: alu_conv

Overview:
- 8-bit registered ALU with an input operand mux.
- Operand A comes from one of two sources (a0_mux / a1_mux), selected by a_sel. Operand B comes directly from b.
- One of eight operations is chosen by ctrl. The result is registered with one-cycle latency.
- Sits in the datapath between the register-file/immediate muxing and the writeback register.

Parameters:
- WIDTH, 8, data width of a0_mux, a1_mux, b and out.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operands/ctrl valid this cycle
- a0_mux  input  WIDTH  operand A source 0
- a1_mux  input  WIDTH  operand A source 1
- a_sel  input  1  0 selects a0_mux, 1 selects a1_mux
- b  input  WIDTH  operand B
- ctrl  input  3  operation select
- out  output  WIDTH  registered result
- out_valid  output  1  out holds a fresh result
- flags  output  4  {negative, zero, carry, overflow}; only meaningful with ALU_FLAGS_EN

Behaviour:
- Interface: one clock; reset is asynchronous and active-low (clk, rst_n).
- Reset: while rst_n=0, out=0, out_valid=0 and flags=0. Reset asserted mid-operation discards any pending result immediately.
- Operand A: A = a_sel ? a1_mux : a0_mux. B = b.
- Operation encoding (all results truncated to WIDTH bits):
  - 000 ADD: A+B
  - 001 SUB: A-B, two's complement, wraps modulo 2^WIDTH
  - 010 OR: A|B
  - 011 AND: A&B
  - 100 XOR: A^B
  - 101 NOT: ~A (B ignored)
  - 110 LSL: A shifted left by the full unsigned value of B, zero fill
  - 111 LSR: A shifted right by the full unsigned value of B, zero fill
- Shift range: a shift amount >= WIDTH yields 0. Example: 0x31 LSL 0x10 = 0x00.
- Timing: on each rising clk with in_valid=1, out <= result and out_valid <= 1.
- When in_valid=0 at a rising edge, out holds its previous value and out_valid <= 0.
- No backpressure. A new operation may be issued every cycle, and the result appears exactly 1 cycle after issue.
- Operands and ctrl are sampled only at the clock edge; changes between edges have no effect.

Optional Feature:
- Macro: ALU_FLAGS_EN.
- Defined: flags register alongside out, updated under the same in_valid rule.
  - negative = result[WIDTH-1]
  - zero = (result==0)
  - carry:
    - ADD: carry-out.
    - SUB: borrow, i.e. 1 when A<B unsigned.
    - LSL: last bit shifted out (0 if shift amount is 0 or >WIDTH).
    - LSR: last bit shifted out (0 if shift amount is 0 or >WIDTH).
    - Logic ops: 0.
  - overflow: signed overflow for ADD/SUB, otherwise 0.
- Not defined: flags is tied to 4'b0000 and no flag logic is synthesized.

Decomposition:
- Shared package alu_pkg:
  - Op-code localparams OP_ADD..OP_LSR (3-bit).
  - Flag bit-index constants.
  - WIDTH default.
- One natural sub-module, alu_core: purely combinational A/B/ctrl -> result (+flags).
- alu_conv contains the A mux, the output/flag registers and valid tracking.

Test Plan:
- Reset: hold rst_n=0 with in_valid=1 and live operands -> out=0x00, out_valid=0. Release rst_n -> first result appears on the following edge.
- ADD/SUB, a_sel=1:
  - a1=0x10, b=0x10, ADD -> 0x20.
  - a1=0x07, b=0x07, ADD -> 0x0E.
  - a1=0x41, b=0x03, SUB -> 0x3E.
  - a1=0x4A, b=0x10, SUB -> 0x3A.
  - a1=0x00, b=0x01, SUB -> 0xFF; with flags: carry=1, negative=1.
- Logic, a_sel=1:
  - a1=0x01, b=0x12, OR -> 0x13.
  - a1=0x03, b=0x10, AND -> 0x00; with flags: zero=1.
  - a1=0x22, b=0x12, XOR -> 0x30.
  - a1=0x47, NOT -> 0xB8.
- Shifts, a_sel=1:
  - a1=0x02, b=0x01, LSL -> 0x04.
  - a1=0x31, b=0x10, LSL -> 0x00.
  - a1=0x06, b=0x02, LSR -> 0x01.
  - a1=0xFF, b=0x22, LSR -> 0x00.
- Mux select: a0=0x08, a1=0x10, b=0x10, ADD; a_sel=0 -> 0x18, a_sel=1 -> 0x20.
- Valid/pipelining:
  - Back-to-back issues -> one result per cycle, each 1 cycle after issue.
  - Deassert in_valid -> out holds its last value, out_valid=0.
  - Assert rst_n=0 mid-stream -> out=0 immediately, asynchronously.
